// File: rtl/decode_issue_reg.sv
`default_nettype none
// ============================================================================
//  Module      : decode_issue_reg
//  Description : RV32I/M/Zicsr instruction decoder fused with the ID/EX
//                control register. Flags illegal encodings and holds
//                multi-cycle MUL/DIV operations in EX while requesting an
//                upstream stall.
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_issue_reg #(
  parameter int EN_M       = 1,
  parameter int EN_CSR     = 1,
  parameter int ALU_CTRL_W = 5,
  parameter int MUL_LAT    = 2,
  parameter int DIV_LAT    = 16
) (
  input  logic                  CPU_CLK,
  input  logic                  CPU_RST,
  input  logic [31:0]           InstrD,
  input  logic                  ValidD,
  input  logic                  StallE,
  input  logic                  FlushE,
  output logic                  JalD,
  output logic                  BusyD,
  output logic                  ValidE,
  output logic                  IllegalE,
  output logic                  JalrE,
  output logic [2:0]            RegWriteE,
  output logic                  MemToRegE,
  output logic                  LoadNpcE,
  output logic [3:0]            MemWriteE,
  output logic [1:0]            RegReadE,
  output logic [2:0]            BranchTypeE,
  output logic [2:0]            ImmTypeE,
  output logic                  AluSrc1E,
  output logic [1:0]            AluSrc2E,
  output logic [ALU_CTRL_W-1:0] AluContrlE,
  output logic [1:0]            CsrOpE,
  output logic                  CsrImmE
);

  // Opcodes
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [6:0] FN7_BASE = 7'b0000000;
  localparam logic [6:0] FN7_ALT  = 7'b0100000;
  localparam logic [6:0] FN7_MUL  = 7'b0000001;

  // Register write modes
  localparam logic [2:0] NOREGWRITE = 3'd0;
  localparam logic [2:0] RW_LB      = 3'd1;
  localparam logic [2:0] RW_LH      = 3'd2;
  localparam logic [2:0] RW_LW      = 3'd3;
  localparam logic [2:0] RW_LBU     = 3'd4;
  localparam logic [2:0] RW_LHU     = 3'd5;

  // Branch types
  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_BLT  = 3'd3;
  localparam logic [2:0] BR_BLTU = 3'd4;
  localparam logic [2:0] BR_BGE  = 3'd5;
  localparam logic [2:0] BR_BGEU = 3'd6;

  // Immediate types
  localparam logic [2:0] IMM_R = 3'd0;
  localparam logic [2:0] IMM_I = 3'd1;
  localparam logic [2:0] IMM_S = 3'd2;
  localparam logic [2:0] IMM_B = 3'd3;
  localparam logic [2:0] IMM_U = 3'd4;
  localparam logic [2:0] IMM_J = 3'd5;

  // RV32I ALU operation codes (zero-extended onto AluContrl)
  localparam logic [3:0] ALU_SLL  = 4'd0;
  localparam logic [3:0] ALU_SRL  = 4'd1;
  localparam logic [3:0] ALU_SRA  = 4'd2;
  localparam logic [3:0] ALU_ADD  = 4'd3;
  localparam logic [3:0] ALU_SUB  = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_OR   = 4'd6;
  localparam logic [3:0] ALU_AND  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_LUI  = 4'd10;

  // Counter reload values: an L-cycle op stays busy for L-1 extra cycles
  localparam logic [5:0] MUL_RELOAD = 6'(MUL_LAT - 1);
  localparam logic [5:0] DIV_RELOAD = 6'(DIV_LAT - 1);

  typedef struct packed {
    logic                  illegal;
    logic                  jalr;
    logic [2:0]            reg_write;
    logic                  mem_to_reg;
    logic                  load_npc;
    logic [3:0]            mem_write;
    logic [1:0]            reg_read;
    logic [2:0]            branch_type;
    logic [2:0]            imm_type;
    logic                  alu_src1;
    logic [1:0]            alu_src2;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
    logic [1:0]            csr_op;
    logic                  csr_imm;
  } ctrl_t;

  function automatic logic [ALU_CTRL_W-1:0] alu_code(input logic [3:0] code);
    return {{(ALU_CTRL_W-4){1'b0}}, code};
  endfunction

  // M-extension ops: MSB set, low three bits carry Fn3
  function automatic logic [ALU_CTRL_W-1:0] m_code(input logic [2:0] fn3);
    logic [ALU_CTRL_W-1:0] c;
    c = '0;
    c[ALU_CTRL_W-1] = 1'b1;
    c[2:0] = fn3;
    return c;
  endfunction

  // The bubble / illegal control set: no side effects, ALU does ADD
  function automatic ctrl_t nop_ctrl();
    ctrl_t c;
    c = '0;
    c.reg_write = NOREGWRITE;
    c.imm_type  = IMM_R;
    c.alu_ctrl  = alu_code(ALU_ADD);
    return c;
  endfunction

  logic [6:0] opcode;
  logic [2:0] fn3;
  logic [6:0] fn7;
  logic       unused_fields;

  assign opcode = InstrD[6:0];
  assign fn3    = InstrD[14:12];
  assign fn7    = InstrD[31:25];
  // Register indices and immediates are extracted elsewhere in the pipeline
  assign unused_fields = ^{InstrD[24:15], InstrD[11:7]};

  ctrl_t      dec;
  logic       legal;
  logic       m_op;
  logic       m_load;
  logic [5:0] reload;

  ctrl_t      ex;
  logic       valid_e;
  logic [5:0] cnt;

  // Combinational decode of the ID-stage instruction
  always_comb begin
    dec   = nop_ctrl();
    legal = 1'b1;
    m_op  = 1'b0;
    case (opcode)
      OP_LUI: begin
        dec.reg_write = RW_LW;
        dec.imm_type  = IMM_U;
        dec.alu_src2  = 2'b10;
        dec.alu_ctrl  = alu_code(ALU_LUI);
      end
      OP_AUIPC: begin
        dec.reg_write = RW_LW;
        dec.imm_type  = IMM_U;
        dec.alu_src1  = 1'b1;
        dec.alu_src2  = 2'b10;
      end
      OP_JAL: begin
        dec.reg_write = RW_LW;
        dec.load_npc  = 1'b1;
        dec.imm_type  = IMM_J;
      end
      OP_JALR: begin
        legal         = (fn3 == 3'b000);
        dec.jalr      = 1'b1;
        dec.reg_write = RW_LW;
        dec.load_npc  = 1'b1;
        dec.reg_read  = 2'b10;
        dec.imm_type  = IMM_I;
        dec.alu_src2  = 2'b10;
      end
      OP_BRANCH: begin
        dec.reg_read = 2'b11;
        dec.imm_type = IMM_B;
        case (fn3)
          3'b000:  dec.branch_type = BR_BEQ;
          3'b001:  dec.branch_type = BR_BNE;
          3'b100:  dec.branch_type = BR_BLT;
          3'b101:  dec.branch_type = BR_BGE;
          3'b110:  dec.branch_type = BR_BLTU;
          3'b111:  dec.branch_type = BR_BGEU;
          default: legal = 1'b0;
        endcase
      end
      OP_LOAD: begin
        dec.mem_to_reg = 1'b1;
        dec.reg_read   = 2'b10;
        dec.imm_type   = IMM_I;
        dec.alu_src2   = 2'b10;
        case (fn3)
          3'b000:  dec.reg_write = RW_LB;
          3'b001:  dec.reg_write = RW_LH;
          3'b010:  dec.reg_write = RW_LW;
          3'b100:  dec.reg_write = RW_LBU;
          3'b101:  dec.reg_write = RW_LHU;
          default: legal = 1'b0;
        endcase
      end
      OP_STORE: begin
        dec.reg_read = 2'b11;
        dec.imm_type = IMM_S;
        dec.alu_src2 = 2'b10;
        case (fn3)
          3'b000:  dec.mem_write = 4'b0001;
          3'b001:  dec.mem_write = 4'b0011;
          3'b010:  dec.mem_write = 4'b1111;
          default: legal = 1'b0;
        endcase
      end
      OP_IMM: begin
        dec.reg_write = RW_LW;
        dec.reg_read  = 2'b10;
        dec.imm_type  = IMM_I;
        dec.alu_src2  = 2'b10;
        case (fn3)
          3'b000: dec.alu_ctrl = alu_code(ALU_ADD);
          3'b010: dec.alu_ctrl = alu_code(ALU_SLT);
          3'b011: dec.alu_ctrl = alu_code(ALU_SLTU);
          3'b100: dec.alu_ctrl = alu_code(ALU_XOR);
          3'b110: dec.alu_ctrl = alu_code(ALU_OR);
          3'b111: dec.alu_ctrl = alu_code(ALU_AND);
          3'b001: begin
            // Shift amount comes from the rs2 field
            dec.alu_src2 = 2'b01;
            dec.alu_ctrl = alu_code(ALU_SLL);
            legal        = (fn7 == FN7_BASE);
          end
          default: begin
            dec.alu_src2 = 2'b01;
            if (fn7 == FN7_BASE)     dec.alu_ctrl = alu_code(ALU_SRL);
            else if (fn7 == FN7_ALT) dec.alu_ctrl = alu_code(ALU_SRA);
            else                     legal = 1'b0;
          end
        endcase
      end
      OP_REG: begin
        dec.reg_write = RW_LW;
        dec.reg_read  = 2'b11;
        dec.imm_type  = IMM_R;
        if (fn7 == FN7_BASE) begin
          case (fn3)
            3'b000:  dec.alu_ctrl = alu_code(ALU_ADD);
            3'b001:  dec.alu_ctrl = alu_code(ALU_SLL);
            3'b010:  dec.alu_ctrl = alu_code(ALU_SLT);
            3'b011:  dec.alu_ctrl = alu_code(ALU_SLTU);
            3'b100:  dec.alu_ctrl = alu_code(ALU_XOR);
            3'b101:  dec.alu_ctrl = alu_code(ALU_SRL);
            3'b110:  dec.alu_ctrl = alu_code(ALU_OR);
            default: dec.alu_ctrl = alu_code(ALU_AND);
          endcase
        end else if (fn7 == FN7_ALT) begin
          if (fn3 == 3'b000)      dec.alu_ctrl = alu_code(ALU_SUB);
          else if (fn3 == 3'b101) dec.alu_ctrl = alu_code(ALU_SRA);
          else                    legal = 1'b0;
        end else if (fn7 == FN7_MUL && EN_M != 0) begin
          dec.alu_ctrl = m_code(fn3);
          m_op         = 1'b1;
        end else begin
          legal = 1'b0;
        end
      end
      OP_SYSTEM: begin
        // Fn3 000 (ECALL/EBREAK) and 100 are trapped as illegal
        legal         = (EN_CSR != 0) && (fn3[1:0] != 2'b00);
        dec.reg_write = RW_LW;
        dec.imm_type  = IMM_I;
        dec.alu_src2  = 2'b00;
        dec.reg_read  = fn3[2] ? 2'b00 : 2'b10;
        dec.csr_op    = fn3[1:0];
        dec.csr_imm   = fn3[2];
      end
      default: legal = 1'b0;
    endcase

    if (!legal || !ValidD) begin
      dec = nop_ctrl();
    end
    dec.illegal = ValidD && !legal;
  end

  assign JalD   = ValidD && (opcode == OP_JAL);
  assign m_load = ValidD && legal && m_op;
  assign reload = fn3[2] ? DIV_RELOAD : MUL_RELOAD;
  assign BusyD  = (cnt != 6'd0);

  // ID/EX register and multi-cycle residency counter: flush > stall > busy > load
  always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
    if (CPU_RST) begin
      ex      <= nop_ctrl();
      valid_e <= 1'b0;
      cnt     <= 6'd0;
    end else if (FlushE) begin
      ex      <= nop_ctrl();
      valid_e <= 1'b0;
      cnt     <= 6'd0;
    end else if (!StallE) begin
      if (cnt != 6'd0) begin
        cnt <= cnt - 6'd1;
      end else begin
        ex      <= dec;
        valid_e <= ValidD;
        cnt     <= m_load ? reload : 6'd0;
      end
    end
  end

  assign ValidE      = valid_e;
  assign IllegalE    = ex.illegal;
  assign JalrE       = ex.jalr;
  assign RegWriteE   = ex.reg_write;
  assign MemToRegE   = ex.mem_to_reg;
  assign LoadNpcE    = ex.load_npc;
  assign MemWriteE   = ex.mem_write;
  assign RegReadE    = ex.reg_read;
  assign BranchTypeE = ex.branch_type;
  assign ImmTypeE    = ex.imm_type;
  assign AluSrc1E    = ex.alu_src1;
  assign AluSrc2E    = ex.alu_src2;
  assign AluContrlE  = ex.alu_ctrl;
  assign CsrOpE      = ex.csr_op;
  assign CsrImmE     = ex.csr_imm;

endmodule
`default_nettype wire

// File: tb/tb_decode_issue_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decode_issue_reg
//  Description : Directed, table-driven bench for decode_issue_reg with
//                hand sequences for the multi-cycle issue corner cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_issue_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        vld, stall, flush;

  // Main instance (defaults)
  logic jald, busy, valid_e, ill, jalr, m2r, npc, s1, cimm;
  logic [2:0] rw, bt, it;
  logic [3:0] mw;
  logic [1:0] rr, s2, cop;
  logic [4:0] alu;
  // EN_M = 0 instance
  logic n_jald, n_busy, n_valid, n_ill, n_jalr, n_m2r, n_npc, n_s1, n_cimm;
  logic [2:0] n_rw, n_bt, n_it;
  logic [3:0] n_mw;
  logic [1:0] n_rr, n_s2, n_cop;
  logic [4:0] n_alu;
  // Single-cycle latency, EN_CSR = 0 instance
  logic l_jald, l_busy, l_valid, l_ill, l_jalr, l_m2r, l_npc, l_s1, l_cimm;
  logic [2:0] l_rw, l_bt, l_it;
  logic [3:0] l_mw;
  logic [1:0] l_rr, l_s2, l_cop;
  logic [4:0] l_alu;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decode_issue_reg dut (
    .CPU_CLK(clk), .CPU_RST(rst), .InstrD(instr), .ValidD(vld), .StallE(stall), .FlushE(flush),
    .JalD(jald), .BusyD(busy), .ValidE(valid_e), .IllegalE(ill), .JalrE(jalr), .RegWriteE(rw),
    .MemToRegE(m2r), .LoadNpcE(npc), .MemWriteE(mw), .RegReadE(rr), .BranchTypeE(bt),
    .ImmTypeE(it), .AluSrc1E(s1), .AluSrc2E(s2), .AluContrlE(alu), .CsrOpE(cop), .CsrImmE(cimm)
  );

  decode_issue_reg #(.EN_M(0)) dut_nom (
    .CPU_CLK(clk), .CPU_RST(rst), .InstrD(instr), .ValidD(vld), .StallE(stall), .FlushE(flush),
    .JalD(n_jald), .BusyD(n_busy), .ValidE(n_valid), .IllegalE(n_ill), .JalrE(n_jalr),
    .RegWriteE(n_rw), .MemToRegE(n_m2r), .LoadNpcE(n_npc), .MemWriteE(n_mw), .RegReadE(n_rr),
    .BranchTypeE(n_bt), .ImmTypeE(n_it), .AluSrc1E(n_s1), .AluSrc2E(n_s2), .AluContrlE(n_alu),
    .CsrOpE(n_cop), .CsrImmE(n_cimm)
  );

  decode_issue_reg #(.EN_CSR(0), .MUL_LAT(1), .DIV_LAT(1)) dut_l1 (
    .CPU_CLK(clk), .CPU_RST(rst), .InstrD(instr), .ValidD(vld), .StallE(stall), .FlushE(flush),
    .JalD(l_jald), .BusyD(l_busy), .ValidE(l_valid), .IllegalE(l_ill), .JalrE(l_jalr),
    .RegWriteE(l_rw), .MemToRegE(l_m2r), .LoadNpcE(l_npc), .MemWriteE(l_mw), .RegReadE(l_rr),
    .BranchTypeE(l_bt), .ImmTypeE(l_it), .AluSrc1E(l_s1), .AluSrc2E(l_s2), .AluContrlE(l_alu),
    .CsrOpE(l_cop), .CsrImmE(l_cimm)
  );

  typedef struct {
    logic [31:0] instr;
    logic        vld;
    logic        jald;
    logic        valid;
    logic        ill;
    logic        jalr;
    logic [2:0]  rw;
    logic        m2r;
    logic        npc;
    logic [3:0]  mw;
    logic [1:0]  rr;
    logic [2:0]  bt;
    logic [2:0]  it;
    logic        s1;
    logic [1:0]  s2;
    logic [4:0]  alu;
    logic [1:0]  cop;
    logic        cimm;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(logic [31:0] i, logic vd, logic jd, logic va, logic il, logic jr,
                             logic [2:0] w, logic mr, logic np, logic [3:0] m, logic [1:0] r,
                             logic [2:0] b, logic [2:0] t, logic a1, logic [1:0] a2,
                             logic [4:0] al, logic [1:0] co, logic ci);
    vec_t e;
    e.instr = i; e.vld = vd; e.jald = jd; e.valid = va; e.ill = il; e.jalr = jr;
    e.rw = w; e.m2r = mr; e.npc = np; e.mw = m; e.rr = r; e.bt = b; e.it = t;
    e.s1 = a1; e.s2 = a2; e.alu = al; e.cop = co; e.cimm = ci;
    return e;
  endfunction

  // Expected E-stage bundle; the last bit is BusyD, zero for single-cycle ops
  function automatic logic [31:0] pk(vec_t e);
    return {e.valid, e.ill, e.jalr, e.rw, e.m2r, e.npc, e.mw, e.rr, e.bt, e.it,
            e.s1, e.s2, e.alu, e.cop, e.cimm, 1'b0};
  endfunction

  function automatic logic [31:0] act();
    return {valid_e, ill, jalr, rw, m2r, npc, mw, rr, bt, it, s1, s2, alu, cop, cimm, busy};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] I_ADD = 32'h002081B3;
  localparam logic [31:0] I_MUL = 32'h022081B3;
  localparam logic [31:0] I_DIV = 32'h0220C1B3;
  localparam logic [31:0] I_CSRRW = 32'h300091F3;

  vec_t nop_e, add_e;
  int   busy_cycles, alu_bad;
  bit   done;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nop_e = v(32'h0, 0,0, 0,0,0, 3'd0,0,0, 4'h0,2'd0, 3'd0,3'd0, 0,2'd0, 5'd3, 2'd0,0);
    add_e = v(I_ADD, 1,0, 1,0,0, 3'd3,0,0, 4'h0,2'd3, 3'd0,3'd0, 0,2'd0, 5'd3, 2'd0,0);

    // instr vld jald | valid ill jalr | rw m2r npc | mw rr | bt it | s1 s2 | alu | cop cimm
    vecs.push_back(add_e);
    vecs.push_back(v(32'h402081B3, 1,0, 1,0,0, 3'd3,0,0, 4'h0,2'd3, 3'd0,3'd0, 0,2'd0, 5'd4,  2'd0,0)); // SUB
    vecs.push_back(v(32'h402091B3, 1,0, 1,1,0, 3'd0,0,0, 4'h0,2'd0, 3'd0,3'd0, 0,2'd0, 5'd3,  2'd0,0)); // SLL/alt
    vecs.push_back(v(32'h0020C1B3, 1,0, 1,0,0, 3'd3,0,0, 4'h0,2'd3, 3'd0,3'd0, 0,2'd0, 5'd5,  2'd0,0)); // XOR
    vecs.push_back(v(32'h042081B3, 1,0, 1,1,0, 3'd0,0,0, 4'h0,2'd0, 3'd0,3'd0, 0,2'd0, 5'd3,  2'd0,0)); // bad fn7
    vecs.push_back(v(32'h00508193, 1,0, 1,0,0, 3'd3,0,0, 4'h0,2'd2, 3'd0,3'd1, 0,2'd2, 5'd3,  2'd0,0)); // ADDI
    vecs.push_back(v(32'h4030D193, 1,0, 1,0,0, 3'd3,0,0, 4'h0,2'd2, 3'd0,3'd1, 0,2'd1, 5'd2,  2'd0,0)); // SRAI
    vecs.push_back(v(32'h40309193, 1,0, 1,1,0, 3'd0,0,0, 4'h0,2'd0, 3'd0,3'd0, 0,2'd0, 5'd3,  2'd0,0)); // SLLI bad
    vecs.push_back(v(32'h0230D193, 1,0, 1,1,0, 3'd0,0,0, 4'h0,2'd0, 3'd0,3'd0, 0,2'd0, 5'd3,  2'd0,0)); // SRLI bad
    vecs.push_back(v(32'h0000A183, 1,0, 1,0,0, 3'd3,1,0, 4'h0,2'd2, 3'd0,3'd1, 0,2'd2, 5'd3,  2'd0,0)); // LW
    vecs.push_back(v(32'h0000D183, 1,0, 1,0,0, 3'd5,1,0, 4'h0,2'd2, 3'd0,3'd1, 0,2'd2, 5'd3,  2'd0,0)); // LHU
    vecs.push_back(v(32'h0000B183, 1,0, 1,1,0, 3'd0,0,0, 4'h0,2'd0, 3'd0,3'd0, 0,2'd0, 5'd3,  2'd0,0)); // load bad
    vecs.push_back(v(32'h0020A023, 1,0, 1,0,0, 3'd0,0,0, 4'hF,2'd3, 3'd0,3'd2, 0,2'd2, 5'd3,  2'd0,0)); // SW
    vecs.push_back(v(32'h00208023, 1,0, 1,0,0, 3'd0,0,0, 4'h1,2'd3, 3'd0,3'd2, 0,2'd2, 5'd3,  2'd0,0)); // SB
    vecs.push_back(v(32'h0020B023, 1,0, 1,1,0, 3'd0,0,0, 4'h0,2'd0, 3'd0,3'd0, 0,2'd0, 5'd3,  2'd0,0)); // store bad
    vecs.push_back(v(32'h00208063, 1,0, 1,0,0, 3'd0,0,0, 4'h0,2'd3, 3'd1,3'd3, 0,2'd0, 5'd3,  2'd0,0)); // BEQ
    vecs.push_back(v(32'h0020C063, 1,0, 1,0,0, 3'd0,0,0, 4'h0,2'd3, 3'd3,3'd3, 0,2'd0, 5'd3,  2'd0,0)); // BLT
    vecs.push_back(v(32'h0020F063, 1,0, 1,0,0, 3'd0,0,0, 4'h0,2'd3, 3'd6,3'd3, 0,2'd0, 5'd3,  2'd0,0)); // BGEU
    vecs.push_back(v(32'h0020A063, 1,0, 1,1,0, 3'd0,0,0, 4'h0,2'd0, 3'd0,3'd0, 0,2'd0, 5'd3,  2'd0,0)); // br bad
    vecs.push_back(v(32'h123451B7, 1,0, 1,0,0, 3'd3,0,0, 4'h0,2'd0, 3'd0,3'd4, 0,2'd2, 5'd10, 2'd0,0)); // LUI
    vecs.push_back(v(32'h12345197, 1,0, 1,0,0, 3'd3,0,0, 4'h0,2'd0, 3'd0,3'd4, 1,2'd2, 5'd3,  2'd0,0)); // AUIPC
    vecs.push_back(v(32'h000000EF, 1,1, 1,0,0, 3'd3,0,1, 4'h0,2'd0, 3'd0,3'd5, 0,2'd0, 5'd3,  2'd0,0)); // JAL
    vecs.push_back(v(32'h000100E7, 1,0, 1,0,1, 3'd3,0,1, 4'h0,2'd2, 3'd0,3'd1, 0,2'd2, 5'd3,  2'd0,0)); // JALR
    vecs.push_back(v(32'h000110E7, 1,0, 1,1,0, 3'd0,0,0, 4'h0,2'd0, 3'd0,3'd0, 0,2'd0, 5'd3,  2'd0,0)); // JALR bad
    vecs.push_back(v(32'h0000007F, 1,0, 1,1,0, 3'd0,0,0, 4'h0,2'd0, 3'd0,3'd0, 0,2'd0, 5'd3,  2'd0,0)); // opcode
    vecs.push_back(v(32'h00000073, 1,0, 1,1,0, 3'd0,0,0, 4'h0,2'd0, 3'd0,3'd0, 0,2'd0, 5'd3,  2'd0,0)); // ECALL
    vecs.push_back(v(32'h00100073, 1,0, 1,1,0, 3'd0,0,0, 4'h0,2'd0, 3'd0,3'd0, 0,2'd0, 5'd3,  2'd0,0)); // EBREAK
    vecs.push_back(v(I_CSRRW,      1,0, 1,0,0, 3'd3,0,0, 4'h0,2'd2, 3'd0,3'd1, 0,2'd0, 5'd3,  2'd1,0)); // CSRRW
    vecs.push_back(v(32'h3002E1F3, 1,0, 1,0,0, 3'd3,0,0, 4'h0,2'd0, 3'd0,3'd1, 0,2'd0, 5'd3,  2'd2,1)); // CSRRSI
    vecs.push_back(v(32'h3000B1F3, 1,0, 1,0,0, 3'd3,0,0, 4'h0,2'd2, 3'd0,3'd1, 0,2'd0, 5'd3,  2'd3,0)); // CSRRC
    vecs.push_back(v(I_ADD,        0,0, 0,0,0, 3'd0,0,0, 4'h0,2'd0, 3'd0,3'd0, 0,2'd0, 5'd3,  2'd0,0)); // bubble
    vecs.push_back(v(32'h000000EF, 0,0, 0,0,0, 3'd0,0,0, 4'h0,2'd0, 3'd0,3'd0, 0,2'd0, 5'd3,  2'd0,0)); // JAL bubble

    rst = 1'b1; instr = 32'h0; vld = 1'b0; stall = 1'b0; flush = 1'b0;
    tick();
    check("reset_state", act(), pk(nop_e));
    @(negedge clk);
    rst = 1'b0;

    // Reset asserted mid-cycle clears E immediately
    instr = I_ADD; vld = 1'b1;
    tick();
    check("pre_reset_add", act(), pk(add_e));
    #2 rst = 1'b1;
    #1 check("async_reset", act(), pk(nop_e));
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("post_reset_add", act(), pk(add_e));

    // Table of single-cycle decodes
    foreach (vecs[k]) begin
      @(negedge clk);
      instr = vecs[k].instr;
      vld   = vecs[k].vld;
      #1 check($sformatf("jald_%0d", k), {31'b0, jald}, {31'b0, vecs[k].jald});
      tick();
      check($sformatf("vec_%0d_%08h", k, vecs[k].instr), act(), pk(vecs[k]));
    end

    // CSR op with EN_CSR=0 is illegal
    @(negedge clk);
    instr = I_CSRRW; vld = 1'b1;
    tick();
    check("nocsr_illegal", {31'b0, l_ill}, 32'd1);
    check("nocsr_regwrite", {29'b0, l_rw}, 32'd0);

    // Bubble carrying a MUL encoding must not start the sequencer
    @(negedge clk);
    instr = I_MUL; vld = 1'b0;
    tick();
    check("mul_bubble_busy", {31'b0, busy}, 32'd0);

    // MUL, latency 2: one busy cycle, then the held ADD loads
    @(negedge clk);
    instr = I_MUL; vld = 1'b1;
    tick();
    check("mul_alu", {27'b0, alu}, 32'h10);
    check("mul_busy_1", {31'b0, busy}, 32'd1);
    check("mul_regread", {30'b0, rr}, 32'd3);
    check("nom_illegal", {31'b0, n_ill}, 32'd1);
    check("nom_busy", {31'b0, n_busy}, 32'd0);
    check("l1_busy", {31'b0, l_busy}, 32'd0);
    check("l1_alu", {27'b0, l_alu}, 32'h10);
    instr = I_ADD;
    tick();
    check("mul_busy_2", {31'b0, busy}, 32'd0);
    check("mul_alu_held", {27'b0, alu}, 32'h10);
    check("nom_busy_2", {31'b0, n_busy}, 32'd0);
    check("l1_next_alu", {27'b0, l_alu}, 32'd3);
    tick();
    check("mul_then_add", act(), pk(add_e));

    // DIV, latency 16, stalled for 3 cycles: busy for 18 cycles
    @(negedge clk);
    instr = I_DIV; vld = 1'b1;
    tick();
    instr = I_ADD;
    busy_cycles = 0; alu_bad = 0; done = 1'b0;
    for (int c = 1; c <= 40 && !done; c++) begin
      if (!busy) begin
        done = 1'b1;
      end else begin
        busy_cycles++;
        if (alu !== 5'h14) alu_bad++;
        stall = (c >= 4 && c <= 6);
        tick();
      end
    end
    stall = 1'b0;
    check("div_done", {31'b0, done}, 32'd1);
    check("div_busy_cycles", busy_cycles, 32'd18);
    check("div_alu_held", alu_bad, 32'd0);
    tick();
    check("div_then_add", act(), pk(add_e));

    // DIV flushed at cycle 5
    @(negedge clk);
    instr = I_DIV; vld = 1'b1;
    tick();
    instr = I_ADD;
    for (int c = 1; c < 5; c++) tick();
    check("flush_pre_busy", {31'b0, busy}, 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", {31'b0, busy}, 32'd0);
    check("flush_state", act(), pk(nop_e));
    tick();
    check("flush_then_add", act(), pk(add_e));

    // Reset in the middle of a DIV leaves no residue
    @(negedge clk);
    instr = I_DIV;
    tick();
    instr = I_ADD;
    tick();
    check("rst_pre_busy", {31'b0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1 check("rst_mid_div", act(), pk(nop_e));
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("rst_then_add", act(), pk(add_e));

    // Flush and stall together: flush wins
    @(negedge clk);
    flush = 1'b1; stall = 1'b1;
    tick();
    check("flush_over_stall", act(), pk(nop_e));
    @(negedge clk);
    flush = 1'b0;
    tick();
    check("stall_holds_nop", act(), pk(nop_e));
    stall = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/decode_issue_reg.md
# decode_issue_reg

Parametrised RV32I/M/Zicsr instruction decoder fused with the ID/EX pipeline register. It decodes the ID-stage instruction and produces the same control-signal set as the existing RV32I decoder. It adds optional M-extension and CSR decode, and illegal-instruction detection. A multi-cycle issue sequencer holds MUL/DIV operations in EX for a configurable latency and requests an upstream stall meanwhile. It sits between the IF/ID register and the EX stage, and replaces the separate decoder plus ID/EX control register.

## Interface
- `EN_M`, 1: decode RV32M (opcode 0110011, Fn7 0000001); 0 makes these illegal.
- `EN_CSR`, 1: decode CSR ops (opcode 1110011); 0 makes these illegal.
- `ALU_CTRL_W`, 5: AluContrl width, minimum 5.
- `MUL_LAT`, 2: EX residency for MUL/MULH/MULHSU/MULHU, 1..63.
- `DIV_LAT`, 16: EX residency for DIV/DIVU/REM/REMU, 1..63.

Ports:
- `CPU_CLK` in 1: the single clock. Rising edge.
- `CPU_RST` in 1: asynchronous, active-high reset.
- `InstrD` in 32: ID-stage instruction.
- `ValidD` in 1: `InstrD` is a real instruction and not a bubble.
- `StallE` in 1: hazard-unit hold of the ID/EX register.
- `FlushE` in 1: hazard-unit clear of the ID/EX register.
- `JalD` out 1: combinational. Valid JAL in ID.
- `BusyD` out 1: registered-state-derived. A multi-cycle op occupies EX, so the hazard unit must stall IF/ID.
- `ValidE` out 1: the EX-stage slot holds an instruction.
- `IllegalE` out 1: the EX instruction is illegal or is ECALL/EBREAK.
- `JalrE` out 1: the EX instruction is JALR.
- `RegWriteE` out 3: register write mode.
- `MemToRegE` out 1: memory-to-register select.
- `LoadNpcE` out 1: load next PC into the result.
- `MemWriteE` out 4: memory byte-write enables.
- `RegReadE` out 2: register-read flags.
- `BranchTypeE` out 3: branch type.
- `ImmTypeE` out 3: immediate type.
- `AluSrc1E` out 1: ALU source-1 select.
- `AluSrc2E` out 2: ALU source-2 select.
- Encodings for all of the above follow Parameters.v.
- `AluContrlE` out `ALU_CTRL_W`: RV32I codes from Parameters.v, zero-extended. M ops use {1'b1, 1'b0…, Fn3}, i.e. MSB set and low 3 bits = Fn3.
- `CsrOpE` out 2: 00 none, 01 RW, 10 RS, 11 RC. Equals Fn3[1:0] for CSR ops.
- `CsrImmE` out 1: immediate-form CSR (Fn3[2]).

## Operation
- RV32I decode matches the team's RV32I decoder for every legal encoding.
- Illegal decode forces all control fields to the NOP set and sets `IllegalE`=1 when latched. The NOP set is:
  - `RegWrite` NOREGWRITE, `MemWrite` 0000, `RegRead` 00, `BranchType` NOBRANCH.
  - `AluContrl` ADD, `ImmType` RTYPE, `AluSrc` 0, `CsrOp` 00, `Jalr`/`Jal`/`LoadNpc`/`MemToReg` 0.
- Conditions that are illegal:
  - Unknown opcode.
  - Load Fn3 ∈ {011,110,111}.
  - Store Fn3 > 010.
  - Branch Fn3 ∈ {010,011}.
  - R-type Fn7 ∉ {0000000, 0100000, 0000001}.
  - Fn7=0100000 with Fn3 ∉ {000,101}.
  - Fn7=0000001 when `EN_M`=0.
  - SLLI with Fn7≠0.
  - SRLI/SRAI with Fn7 ∉ {0000000, 0100000}.
  - JALR Fn3≠000.
  - Opcode 1110011 with Fn3 ∈ {000,100}, which covers ECALL/EBREAK.
  - Opcode 1110011 when `EN_CSR`=0.
- `ValidD`=0 decodes as NOP with `IllegalE`=0 and `ValidE`=0. `JalD` is gated by `ValidD`.
- CSR decode:
  - `RegWrite` LW, `ImmType` ITYPE, `AluSrc2` 00.
  - `RegRead` is 10 for register forms and 00 for immediate forms.
- M decode: `RegWrite` LW, `RegRead` 11, `ImmType` RTYPE.
- Sequencer: a down-counter `cnt`, 6 bits. `BusyD` = (`cnt`≠0).
  - On a load of a valid M op, `cnt` ← LAT−1, using `MUL_LAT` if Fn3[2]=0 and `DIV_LAT` otherwise.
  - While `cnt`≠0 and `StallE`=0: `cnt` decrements and the ID/EX register holds.
  - When `StallE`=1: `cnt` freezes.
- ID/EX register update priority, per rising edge:
  1. `FlushE`: the register takes the NOP set with `ValidE`=0, `IllegalE`=0, and `cnt` ← 0.
  2. `StallE`: hold all state.
  3. `BusyD`: hold the register and decrement `cnt`.
  4. Otherwise: load the decoded `InstrD`.

## Timing
- Decode is combinational within the ID cycle. E outputs change only at the `CPU_CLK` rising edge or on `CPU_RST`.
- Reset (asynchronous, immediate): every E output takes the NOP set, `ValidE`=0, `IllegalE`=0, `CsrOpE`=0, `cnt`=0, `BusyD`=0.
- Reset mid-sequence aborts the op with no residue.
- An op with latency L occupies EX for exactly L cycles when no `StallE` occurs. `BusyD` is high for L−1 cycles, starting the cycle after the load.
- An op with L=1 never raises `BusyD`.
- Back-to-back M ops: the second loads on the edge where `cnt` reaches 0. That edge is the first edge with `BusyD`=0 at the time of sampling.
- `FlushE` and `StallE` both high: flush wins.
- `FlushE` during busy clears `BusyD` in the next cycle.

## Test plan
- Reset, then release:
  - Stimulus: assert `CPU_RST` mid-cycle.
  - Response: all outputs are NOP/0 immediately. With `InstrD`=0x002081B3 (ADD), `ValidD`=1, one edge gives `ValidE`=1, `RegWriteE`=LW, `RegReadE`=11, `AluContrlE`=ADD, `BusyD`=0.
- Illegal detection:
  - Stimulus: 0x402091B3 (SLL with Fn7=0100000).
  - Response: `IllegalE`=1, `RegWriteE`=NOREGWRITE, `MemWriteE`=0000.
  - Stimulus: 0x402081B3.
  - Response: `AluContrlE`=SUB, `IllegalE`=0.
- MUL with `MUL_LAT`=2:
  - Stimulus: 0x022081B3, then ADD.
  - Response: `AluContrlE`=5'b10000. `BusyD`=1 for exactly 1 cycle. ADD appears in E 2 cycles after the MUL load.
- DIV with `DIV_LAT`=16:
  - Stimulus: 0x0220C1B3, with `StallE` high for 3 cycles at cycle 4.
  - Response: `BusyD` is high for 18 cycles and `AluContrlE`=5'b10100 is held throughout.
  - Stimulus: repeat with `FlushE` at cycle 5.
  - Response: `BusyD`=0 and `ValidE`=0 the next cycle.
- Configuration:
  - Stimulus: `EN_M`=0 with 0x022081B3.
  - Response: `IllegalE`=1, `BusyD` never asserts.
  - Stimulus: `EN_CSR`=1 with CSRRSI (Fn3=110).
  - Response: `CsrOpE`=10, `CsrImmE`=1, `RegReadE`=00.
- Priority:
  - Stimulus: `FlushE` and `StallE` high together with a valid ADD in E.
  - Response: `ValidE`=0 after the edge.
